// File: rtl/wide_addsub_seq.sv
// wide_addsub_seq: multi-cycle W-bit add/subtract built from one LIMB_W-bit limb adder.
// One limb is processed per cycle, low limb first, with the carry held in a register
// between limbs. Flags carry the same meaning as the single-cycle 64-bit add/sub stage.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   start            request, sampled in IDLE or DONE
//   mode             0 = A+B, 1 = A-B (latched on start)
//   A, B             W-bit operands (latched on start)
//   busy             high while limbs are being processed
//   done             one-cycle pulse when result and flags are valid
//   result           W-bit sum/difference, held until the next operation's first limb write
//   SF CF OF PF ZF   sign, carry/borrow, signed overflow, low-byte even parity, zero
module wide_addsub_seq #(
    parameter int unsigned LIMB_W = 64,
    parameter int unsigned LIMBS  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      mode,
    input  logic [LIMB_W*LIMBS-1:0]   A,
    input  logic [LIMB_W*LIMBS-1:0]   B,
    output logic                      busy,
    output logic                      done,
    output logic [LIMB_W*LIMBS-1:0]   result,
    output logic                      SF,
    output logic                      CF,
    output logic                      OF,
    output logic                      PF,
    output logic                      ZF
);

    localparam int unsigned W     = LIMB_W * LIMBS;
    localparam int unsigned IDX_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LIMBS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              last;

    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic              mode_reg;
    logic              carry;
    logic [IDX_W-1:0]  idx;

    logic [LIMB_W-1:0] a_limb;
    logic [LIMB_W-1:0] bx_limb;
    logic [LIMB_W:0]   sum;
    logic [W-1:0]      full_res;
    logic              a_top;
    logic              bx_top;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DONE accepts a new start so operations can run back to back
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (idx == LAST_IDX) begin
                    last      = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Limb adder; subtraction is A + ~B + 1 with the +1 seeded into the carry register
    always_comb begin
        a_limb  = a_reg[idx*LIMB_W +: LIMB_W];
        bx_limb = b_reg[idx*LIMB_W +: LIMB_W] ^ {LIMB_W{mode_reg}};
        sum     = {1'b0, a_limb} + {1'b0, bx_limb} + {{LIMB_W{1'b0}}, carry};
    end

    // Result as it will look after this edge's limb write; flags are taken from it
    always_comb begin
        full_res = result;
        full_res[idx*LIMB_W +: LIMB_W] = sum[LIMB_W-1:0];
        a_top  = a_reg[W-1];
        bx_top = b_reg[W-1] ^ mode_reg;
    end

    // Operand latch, limb sequencing, result and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            mode_reg <= 1'b0;
            carry    <= 1'b0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            SF       <= 1'b0;
            CF       <= 1'b0;
            OF       <= 1'b0;
            PF       <= 1'b0;
            ZF       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_reg    <= A;
                b_reg    <= B;
                mode_reg <= mode;
                carry    <= mode;
                idx      <= '0;
                busy     <= 1'b1;
            end else if (state == S_RUN) begin
                result[idx*LIMB_W +: LIMB_W] <= sum[LIMB_W-1:0];
                carry <= sum[LIMB_W];
                idx   <= idx + 1'b1;
                if (last) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    SF   <= full_res[W-1];
                    CF   <= sum[LIMB_W] ^ mode_reg;
                    OF   <= (a_top == bx_top) && (full_res[W-1] != a_top);
                    PF   <= ~^full_res[7:0];
                    ZF   <= (full_res == '0);
                end
            end
        end
    end

endmodule
